// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder with a bank of NUM_REGS 32-bit read/write registers exported flat.
// Optional macro AXIL_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_slave_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   regs_flat,
    output logic                     wr_pulse
);

    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLAVE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return 64'(addr[ADDR_W-1:2]) < 64'(NUM_REGS);
    endfunction

    function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_W-1:0] addr);
        return addr[SEL_W+1:2];
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    w_state_t          w_state_r, w_state_nx_s;
    r_state_t          r_state_r, r_state_nx_s;
    logic              aw_done_r, aw_done_nx_s;
    logic              w_done_r, w_done_nx_s;
    logic              awready_r, awready_nx_s;
    logic              wready_r, wready_nx_s;
    logic              bvalid_r, bvalid_nx_s;
    logic [1:0]        bresp_r, bresp_nx_s;
    logic [ADDR_W-1:0] awaddr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic              wr_pulse_r;
    logic              commit_s;
    logic              arready_r, arready_nx_s;
    logic              rvalid_r, rvalid_nx_s;
    logic [1:0]        rresp_r, rresp_nx_s;
    logic [31:0]       rdata_r, rdata_nx_s;
    logic [31:0]       regs_r [NUM_REGS];

    logic              aw_hs_s, w_hs_s, ar_hs_s;
    logic              aw_in_range_s, ar_in_range_s;
    logic [SEL_W-1:0]  aw_sel_s, ar_sel_s;

    assign aw_hs_s       = S_AXI_AWVALID && awready_r;
    assign w_hs_s        = S_AXI_WVALID && wready_r;
    assign ar_hs_s       = S_AXI_ARVALID && arready_r;
    assign aw_in_range_s = addr_in_range(awaddr_r);
    assign aw_sel_s      = addr_sel(awaddr_r);
    assign ar_in_range_s = addr_in_range(S_AXI_ARADDR);
    assign ar_sel_s      = addr_sel(S_AXI_ARADDR);

    // Write FSM next-state: capture AW/W independently, commit one cycle after both are held.
    always_comb begin
        w_state_nx_s = w_state_r;
        aw_done_nx_s = aw_done_r;
        w_done_nx_s  = w_done_r;
        awready_nx_s = awready_r;
        wready_nx_s  = wready_r;
        bvalid_nx_s  = bvalid_r;
        bresp_nx_s   = bresp_r;
        commit_s     = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_done_r && w_done_r) begin
                    commit_s     = 1'b1;
                    aw_done_nx_s = 1'b0;
                    w_done_nx_s  = 1'b0;
                    awready_nx_s = 1'b0;
                    wready_nx_s  = 1'b0;
                    bvalid_nx_s  = 1'b1;
                    bresp_nx_s   = aw_in_range_s ? RESP_OKAY : RESP_OOR;
                    w_state_nx_s = W_RESP;
                end else begin
                    aw_done_nx_s = aw_done_r || aw_hs_s;
                    w_done_nx_s  = w_done_r || w_hs_s;
                    awready_nx_s = !(aw_done_r || aw_hs_s);
                    wready_nx_s  = !(w_done_r || w_hs_s);
                end
            end
            W_RESP: begin
                if (bvalid_r && S_AXI_BREADY) begin
                    bvalid_nx_s  = 1'b0;
                    awready_nx_s = 1'b1;
                    wready_nx_s  = 1'b1;
                    w_state_nx_s = W_IDLE;
                end else begin
                    awready_nx_s = 1'b0;
                    wready_nx_s  = 1'b0;
                end
            end
            default: begin
                w_state_nx_s = W_IDLE;
                aw_done_nx_s = 1'b0;
                w_done_nx_s  = 1'b0;
                awready_nx_s = 1'b0;
                wready_nx_s  = 1'b0;
                bvalid_nx_s  = 1'b0;
                bresp_nx_s   = RESP_OKAY;
            end
        endcase
    end

    // Write FSM state, captured write channel payloads and update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r  <= W_IDLE;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            awaddr_r   <= '0;
            wdata_r    <= 32'h0;
            wstrb_r    <= 4'h0;
            wr_pulse_r <= 1'b0;
        end else begin
            w_state_r  <= w_state_nx_s;
            aw_done_r  <= aw_done_nx_s;
            w_done_r   <= w_done_nx_s;
            awready_r  <= awready_nx_s;
            wready_r   <= wready_nx_s;
            bvalid_r   <= bvalid_nx_s;
            bresp_r    <= bresp_nx_s;
            awaddr_r   <= aw_hs_s ? S_AXI_AWADDR : awaddr_r;
            wdata_r    <= w_hs_s ? S_AXI_WDATA : wdata_r;
            wstrb_r    <= w_hs_s ? S_AXI_WSTRB : wstrb_r;
            wr_pulse_r <= commit_s && aw_in_range_s;
        end
    end

    // Register bank; a zero strobe still counts as an update but leaves the value intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= 32'h0;
            end
        end else if (commit_s && aw_in_range_s) begin
            regs_r[aw_sel_s] <= byte_merge(regs_r[aw_sel_s], wdata_r, wstrb_r);
        end else begin
            regs_r <= regs_r;
        end
    end

    // Read FSM next-state: data sampled from the bank before any same-edge write lands.
    always_comb begin
        r_state_nx_s = r_state_r;
        arready_nx_s = arready_r;
        rvalid_nx_s  = rvalid_r;
        rresp_nx_s   = rresp_r;
        rdata_nx_s   = rdata_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_nx_s = R_DATA;
                    arready_nx_s = 1'b0;
                    rvalid_nx_s  = 1'b1;
                    if (ar_in_range_s) begin
                        rdata_nx_s = regs_r[ar_sel_s];
                        rresp_nx_s = RESP_OKAY;
                    end else begin
                        rdata_nx_s = 32'h0;
                        rresp_nx_s = RESP_OOR;
                    end
                end else begin
                    arready_nx_s = 1'b1;
                end
            end
            R_DATA: begin
                if (rvalid_r && S_AXI_RREADY) begin
                    r_state_nx_s = R_IDLE;
                    rvalid_nx_s  = 1'b0;
                    arready_nx_s = 1'b1;
                end else begin
                    arready_nx_s = 1'b0;
                end
            end
            default: begin
                r_state_nx_s = R_IDLE;
                arready_nx_s = 1'b0;
                rvalid_nx_s  = 1'b0;
                rresp_nx_s   = RESP_OKAY;
                rdata_nx_s   = 32'h0;
            end
        endcase
    end

    // Read FSM state and registered read channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= 32'h0;
        end else begin
            r_state_r <= r_state_nx_s;
            arready_r <= arready_nx_s;
            rvalid_r  <= rvalid_nx_s;
            rresp_r   <= rresp_nx_s;
            rdata_r   <= rdata_nx_s;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[32*k +: 32] = regs_r[k];
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign wr_pulse      = wr_pulse_r;

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder holding a bank of NUM_REGS 32-bit read/write registers. Pairs with the AXI4-Lite master on the same bus and answers its write address/data/response and read address/data channels. Write and read paths are independent state machines, each supporting one outstanding transaction. Register contents are also exported flat for downstream logic.

## Interface
- NUM_REGS, 8: number of 32-bit registers; legal range 1..256.
- ADDR_W, 32: width of AWADDR/ARADDR.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- S_AXI_AWADDR  input  ADDR_W  write address.
- S_AXI_AWVALID  input  1  write address valid.
- S_AXI_AWREADY  output  1  write address ready.
- S_AXI_WDATA  input  32  write data.
- S_AXI_WSTRB  input  4  byte enables; bit i gates WDATA[8i+7:8i].
- S_AXI_WVALID  input  1  write data valid.
- S_AXI_WREADY  output  1  write data ready.
- S_AXI_BRESP  output  2  write response.
- S_AXI_BVALID  output  1  write response valid.
- S_AXI_BREADY  input  1  write response ready.
- S_AXI_ARADDR  input  ADDR_W  read address.
- S_AXI_ARVALID  input  1  read address valid.
- S_AXI_ARREADY  output  1  read address ready.
- S_AXI_RDATA  output  32  read data.
- S_AXI_RRESP  output  2  read response.
- S_AXI_RVALID  output  1  read data valid.
- S_AXI_RREADY  input  1  read data ready.
- regs_flat  output  32*NUM_REGS  register k at bits [32k+31:32k].
- wr_pulse  output  1  one-cycle pulse when a register is updated.

## Operation
- Decode: word index = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored; in range iff index < NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
- W_IDLE: AWREADY=1 until AW captured, WREADY=1 until W captured; AW and W accepted in either order or same cycle; captured side drops its READY and holds its value.
- Once both captured: commit (byte-masked write to in-range register, wr_pulse=1), set BVALID, BRESP, go to W_RESP; AWREADY=WREADY=0 in W_RESP.
- W_RESP: hold BVALID/BRESP stable until BVALID&&BREADY, then W_IDLE with READYs re-asserted next cycle.
- Read FSM states: R_IDLE, R_DATA. R_IDLE: ARREADY=1; on ARVALID&&ARREADY register RDATA/RRESP, RVALID=1, go R_DATA (ARREADY=0).
- R_DATA: hold RVALID/RDATA/RRESP stable until RVALID&&RREADY, then R_IDLE.
- Out-of-range write: no register modified, wr_pulse stays 0. Out-of-range read: RDATA=0.
- Response code per Configuration; in-range always OKAY (2'b00).
- WSTRB=4'b0000 in range: handshake completes, OKAY, register unchanged, wr_pulse=1.

## Timing
- Reset (rst=1 at edge): all registers 0, all READY/VALID 0, BRESP=RRESP=0, RDATA=0, wr_pulse=0, FSMs to IDLE; aborts any in-flight transaction. AWREADY/WREADY/ARREADY assert the first cycle after rst deasserts.
- Write latency: AW and W handshakes at edge N -> register updated and BVALID=1 at edge N+1 (visible in cycle after N+1). If AW and W at edges N and M, commit at max(N,M)+1.
- Read latency: AR handshake at edge N -> RVALID=1 with data after edge N.
- Same-cycle read handshake and write commit to same register: read returns pre-write value.
- No combinational path from any input to any output.
- VALID never deasserted without handshake; master may hold BREADY/RREADY low indefinitely.

## Configuration
- AXIL_SLAVE_SLVERR_EN defined: out-of-range write gives BRESP=2'b10 (SLVERR); out-of-range read gives RRESP=2'b10, RDATA=0.
- Not defined: out-of-range accesses respond OKAY (2'b00), writes silently dropped, reads return 0.

## Test plan
- Write 0xDEADBEEF to 0x4 with AW and W same cycle, WSTRB=4'hF -> BVALID one cycle later, BRESP=0, regs_flat[63:32]=0xDEADBEEF, wr_pulse one cycle.
- W presented 3 cycles before AW, then BREADY delayed 2 cycles after BVALID -> BVALID held stable, single commit, READYs return after handshake.
- Write 0x11223344 to reg 2, then WSTRB=4'b0101 data 0xAABBCCDD -> read 0x8 returns 0x11BB33DD, RRESP=0.
- Read address 4*NUM_REGS with and without AXIL_SLAVE_SLVERR_EN -> RDATA=0, RRESP=2'b10 / 2'b00; write there leaves regs_flat unchanged.
- Read and write of reg 0 committing same cycle (old 0x1, new 0x2) -> RDATA=0x1; subsequent read 0x2.
- Assert rst while in W_RESP and R_DATA -> BVALID=RVALID=0, regs_flat=0, READYs high one cycle after rst release.
